// File: rtl/bpu_dyn_bp_pkg.sv
// Shared definitions for the dynamic branch predictor: counter encodings and
// the saturating counter update. Optional RAS is enabled with BPU_RAS_EN.
package bpu_dyn_bp_pkg;

    localparam logic [1:0] CNT_SNT = 2'b00;  // strong not-taken
    localparam logic [1:0] CNT_WNT = 2'b01;  // weak not-taken (reset value)
    localparam logic [1:0] CNT_WT  = 2'b10;  // weak taken
    localparam logic [1:0] CNT_ST  = 2'b11;  // strong taken

    // Link address offset for call pushes
    localparam int LINK_OFS = 4;

    function automatic logic [1:0] cnt_sat(input logic [1:0] c, input logic taken);
        if (taken) return (c == CNT_ST)  ? c : c + 2'd1;
        else       return (c == CNT_SNT) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/bpu_dyn_bp_if.sv
// Lookup / prediction / BJU-update bundle between fetch and the predictor.
interface bpu_dyn_bp_if #(parameter int XLEN = 32);

    logic            i_lookup_fire;
    logic [XLEN-1:0] i_pc;
    logic            i_inst_jal;
    logic            i_inst_jalr;
    logic            i_inst_bxx;
    logic            i_inst_rs1ren;
    logic            i_inst_rd_link;
    logic            i_inst_rs1_link;
    logic [XLEN-1:0] i_imm;
    logic            o_prdt_taken;
    logic [XLEN-1:0] o_prdt_pc;
    logic            i_upd_vld;
    logic [XLEN-1:0] i_upd_pc;
    logic            i_upd_taken;
    logic            i_flush;

    modport master (
        output i_lookup_fire, i_pc, i_inst_jal, i_inst_jalr, i_inst_bxx,
               i_inst_rs1ren, i_inst_rd_link, i_inst_rs1_link, i_imm,
               i_upd_vld, i_upd_pc, i_upd_taken, i_flush,
        input  o_prdt_taken, o_prdt_pc
    );

    modport slave (
        input  i_lookup_fire, i_pc, i_inst_jal, i_inst_jalr, i_inst_bxx,
               i_inst_rs1ren, i_inst_rd_link, i_inst_rs1_link, i_imm,
               i_upd_vld, i_upd_pc, i_upd_taken, i_flush,
        output o_prdt_taken, o_prdt_pc
    );

endinterface

// File: rtl/bpu_dyn_bp_ras.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry and the count saturates. Flush empties the stack and overrides any
// same-cycle push/pop/replace. Only instantiated when BPU_RAS_EN is defined.
module bpu_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_repl,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_push_val,
    output logic            o_vld,
    output logic [XLEN-1:0] o_top
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

    // ptr_q is the next write slot; the top of stack sits one below it
    logic [PW-1:0]   ptr_q, ptr_d, top_idx, widx;
    logic [PW:0]     cnt_q, cnt_d;
    logic            we;
    logic [XLEN-1:0] ent_q [RAS_DEPTH];

    assign top_idx = ptr_q - 1'b1;
    assign o_vld   = (cnt_q != '0);
    assign o_top   = ent_q[top_idx];

    // Next-state for pointer/count and the single entry write port
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        we    = 1'b0;
        widx  = ptr_q;
        if (i_flush) begin
            cnt_d = '0;
        end else if (i_repl) begin
            we   = 1'b1;
            widx = top_idx;
        end else if (i_push) begin
            we    = 1'b1;
            ptr_d = ptr_q + 1'b1;
            cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
        end else if (i_pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Stack state registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ent_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (we) ent_q[widx] <= i_push_val;
        end
    end

endmodule

// File: rtl/bpu_dyn_bp.sv
// Dynamic branch predictor: 2-bit counter BHT for conditional branches,
// always-taken jal / rs1-free jalr, optional return-address stack when
// BPU_RAS_EN is defined (default build: returns predict not-taken).
module bpu_dyn_bp
    import bpu_dyn_bp_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int RAS_DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    bpu_dyn_bp_if.slave  bus
);

    localparam int IDXW = $clog2(BHT_DEPTH);

    logic [1:0]      bht_q [BHT_DEPTH];
    logic [1:0]      cnt_d;
    logic [IDXW-1:0] lk_idx, up_idx;
    logic            is_ret, ras_vld;
    logic [XLEN-1:0] ras_top, seq_tgt;

    assign lk_idx  = bus.i_pc[IDXW+1:2];
    assign up_idx  = bus.i_upd_pc[IDXW+1:2];
    assign seq_tgt = bus.i_pc + bus.i_imm;
    assign is_ret  = bus.i_inst_jalr & bus.i_inst_rs1ren &
                     bus.i_inst_rs1_link & ~bus.i_inst_rd_link;
    assign cnt_d   = cnt_sat(bht_q[up_idx], bus.i_upd_taken);

`ifdef BPU_RAS_EN
    logic push, pop, repl;
    // A link jalr through a link register both returns and calls: swap the
    // top in place. On an empty stack there is nothing to swap, so push.
    assign push = bus.i_lookup_fire & (bus.i_inst_jal | bus.i_inst_jalr) & bus.i_inst_rd_link;
    assign repl = push & bus.i_inst_jalr & bus.i_inst_rs1ren & bus.i_inst_rs1_link & ras_vld;
    assign pop  = bus.i_lookup_fire & is_ret & ras_vld;

    bpu_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_push     (push & ~repl),
        .i_pop      (pop),
        .i_repl     (repl),
        .i_flush    (bus.i_flush),
        .i_push_val (bus.i_pc + XLEN'(LINK_OFS)),
        .o_vld      (ras_vld),
        .o_top      (ras_top)
    );
`else
    assign ras_vld = 1'b0;
    assign ras_top = '0;
    logic unused_ras;
    assign unused_ras = ^{bus.i_lookup_fire, bus.i_flush, ras_top};
`endif

    logic unused_pc;
    assign unused_pc = ^{bus.i_upd_pc[XLEN-1:IDXW+2], bus.i_upd_pc[1:0]};

    // Combinational prediction; the not-taken target is still pc+imm
    always_comb begin
        bus.o_prdt_taken = 1'b0;
        bus.o_prdt_pc    = seq_tgt;
        if (bus.i_inst_bxx) begin
            bus.o_prdt_taken = bht_q[lk_idx][1];
        end else if (bus.i_inst_jal) begin
            bus.o_prdt_taken = 1'b1;
        end else if (bus.i_inst_jalr & ~bus.i_inst_rs1ren) begin
            bus.o_prdt_taken = 1'b1;
            bus.o_prdt_pc    = bus.i_imm;
        end else if (is_ret & ras_vld) begin
            bus.o_prdt_taken = 1'b1;
            bus.o_prdt_pc    = ras_top;
        end
    end

    // BHT training from BJU resolution; lookups see the pre-update value
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CNT_WNT;
        end else if (bus.i_upd_vld) begin
            bht_q[up_idx] <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bpu_dyn_bp.sv
// Self-checking bench for bpu_dyn_bp: directed scenarios plus random traffic
// against a behavioural model (counter array + queue-based return stack).
module tb_bpu_dyn_bp;

    localparam int XLEN = 32;
    localparam int BHTD = 64;
    localparam int RASD = 4;
`ifdef BPU_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    bpu_dyn_bp_if #(.XLEN(XLEN)) bus ();

    bpu_dyn_bp #(.XLEN(XLEN), .BHT_DEPTH(BHTD), .RAS_DEPTH(RASD)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // model state
    int          bht_m [BHTD];
    logic [31:0] ras_m [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < BHTD; i++) bht_m[i] = 1;
        ras_m.delete();
    endtask

    function automatic bit is_ret_m();
        return bus.i_inst_jalr && bus.i_inst_rs1ren && bus.i_inst_rs1_link && !bus.i_inst_rd_link;
    endfunction

    task automatic model_pred(output logic et, output logic [31:0] ep);
        int idx;
        idx = int'((bus.i_pc >> 2) % BHTD);
        et  = 1'b0;
        ep  = bus.i_pc + bus.i_imm;
        if (bus.i_inst_bxx) et = (bht_m[idx] >= 2);
        else if (bus.i_inst_jal) et = 1'b1;
        else if (bus.i_inst_jalr && !bus.i_inst_rs1ren) begin et = 1'b1; ep = bus.i_imm; end
        else if (RAS_ON && is_ret_m() && ras_m.size() > 0) begin et = 1'b1; ep = ras_m[$]; end
    endtask

    task automatic model_upd();
        bit push;
        if (bus.i_upd_vld) begin
            int u;
            u = int'((bus.i_upd_pc >> 2) % BHTD);
            if (bus.i_upd_taken) bht_m[u] = (bht_m[u] == 3) ? 3 : bht_m[u] + 1;
            else                 bht_m[u] = (bht_m[u] == 0) ? 0 : bht_m[u] - 1;
        end
        if (!RAS_ON) return;
        push = bus.i_lookup_fire && (bus.i_inst_jal || bus.i_inst_jalr) && bus.i_inst_rd_link;
        if (bus.i_flush) ras_m.delete();
        else if (push && bus.i_inst_jalr && bus.i_inst_rs1ren && bus.i_inst_rs1_link && ras_m.size() > 0)
            ras_m[ras_m.size()-1] = bus.i_pc + 32'd4;
        else if (push) begin
            ras_m.push_back(bus.i_pc + 32'd4);
            if (ras_m.size() > RASD) void'(ras_m.pop_front());
        end else if (bus.i_lookup_fire && is_ret_m() && ras_m.size() > 0)
            void'(ras_m.pop_back());
    endtask

    // check prediction against model, then clock and advance the model
    task automatic step();
        logic et; logic [31:0] ep;
        #1;
        model_pred(et, ep);
        chk("prdt_taken", {31'd0, bus.o_prdt_taken}, {31'd0, et});
        chk("prdt_pc", bus.o_prdt_pc, ep);
        @(posedge clk);
        model_upd();
        #1;
    endtask

    task automatic idle();
        bus.i_lookup_fire = 0; bus.i_pc = 0; bus.i_inst_jal = 0; bus.i_inst_jalr = 0;
        bus.i_inst_bxx = 0; bus.i_inst_rs1ren = 0; bus.i_inst_rd_link = 0;
        bus.i_inst_rs1_link = 0; bus.i_imm = 0; bus.i_upd_vld = 0; bus.i_upd_pc = 0;
        bus.i_upd_taken = 0; bus.i_flush = 0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic t);
        idle(); bus.i_upd_vld = 1; bus.i_upd_pc = pc; bus.i_upd_taken = t; step();
    endtask

    task automatic bxx(input logic [31:0] pc, input logic [31:0] imm);
        idle(); bus.i_lookup_fire = 1; bus.i_inst_bxx = 1; bus.i_pc = pc; bus.i_imm = imm;
    endtask

    task automatic call(input logic [31:0] pc);
        idle(); bus.i_lookup_fire = 1; bus.i_inst_jal = 1; bus.i_inst_rd_link = 1;
        bus.i_pc = pc; bus.i_imm = 32'h40;
    endtask

    task automatic ret(input logic [31:0] pc);
        idle(); bus.i_lookup_fire = 1; bus.i_inst_jalr = 1; bus.i_inst_rs1ren = 1;
        bus.i_inst_rs1_link = 1; bus.i_pc = pc;
    endtask

    task automatic exp_pred(input string tag, input logic t, input logic [31:0] pc);
        #1;
        chk({tag, "_taken"}, {31'd0, bus.o_prdt_taken}, {31'd0, t});
        if (t) chk({tag, "_pc"}, bus.o_prdt_pc, pc);
    endtask

    initial begin
        idle();
        model_reset();
        rstn = 1'b0;
        #12;
        exp_pred("rst", 1'b0, 32'h0);
        chk("rst_pc", bus.o_prdt_pc, 32'h0);
        #3 rstn = 1'b1;
        @(posedge clk); #1;

        // reset counter 01 -> not taken, target pc+imm
        bxx(32'h100, 32'hFFFF_FFF8);
        exp_pred("bxx_rst", 1'b0, 32'h0);
        chk("bxx_rst_pc", bus.o_prdt_pc, 32'hF8);
        step();

        upd(32'h100, 1); upd(32'h100, 1);
        bxx(32'h100, 32'hFFFF_FFF8); exp_pred("bxx_t2", 1'b1, 32'hF8); step();
        upd(32'h100, 0); upd(32'h100, 0); upd(32'h100, 0);
        bxx(32'h100, 32'hFFFF_FFF8); exp_pred("bxx_nt3", 1'b0, 32'h0); step();
        upd(32'h100, 0); upd(32'h100, 0); upd(32'h100, 1);
        bxx(32'h100, 32'hFFFF_FFF8); exp_pred("bxx_sat0", 1'b0, 32'h0); step();
        upd(32'h100, 1);
        bxx(32'h100, 32'hFFFF_FFF8); exp_pred("bxx_sat1", 1'b1, 32'hF8); step();

        // same-cycle lookup and update: no bypass
        bxx(32'h40, 32'h10); bus.i_upd_vld = 1; bus.i_upd_pc = 32'h40; bus.i_upd_taken = 1;
        exp_pred("nobyp", 1'b0, 32'h0); step();
        bxx(32'h40, 32'h10); exp_pred("nobyp_next", 1'b1, 32'h50); step();

        // rs1-free jalr targets imm
        idle(); bus.i_inst_jalr = 1; bus.i_pc = 32'h500; bus.i_imm = 32'h1234;
        exp_pred("jalr_abs", 1'b1, 32'h1234); step();

        // call then returns
        call(32'h200); exp_pred("jal", 1'b1, 32'h240); step();
        ret(32'h300); exp_pred("ret1", RAS_ON, 32'h204); step();
        ret(32'h300); exp_pred("ret_empty", 1'b0, 32'h0); step();

        // overflow: five pushes into four entries
        for (int i = 1; i <= 5; i++) begin call(32'h10 * i); step(); end
        for (int i = 5; i >= 2; i--) begin
            ret(32'h800); exp_pred("ras_pop", RAS_ON, 32'h10 * i + 4); step();
        end
        ret(32'h800); exp_pred("ras_pop_empty", 1'b0, 32'h0); step();

        // push, flush next cycle, then return
        call(32'h600); step();
        idle(); bus.i_flush = 1; step();
        ret(32'h700); exp_pred("ret_flushed", 1'b0, 32'h0); step();

        // flush wins over a same-cycle push
        call(32'h610); bus.i_flush = 1; step();
        ret(32'h700); exp_pred("flush_wins", 1'b0, 32'h0); step();

        // reset held across an edge with an update pending discards it
        upd(32'h80, 1);
        bxx(32'h80, 32'h4); exp_pred("pre_rst", 1'b1, 32'h84); step();
        idle(); bus.i_upd_vld = 1; bus.i_upd_pc = 32'h80; bus.i_upd_taken = 1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        model_reset();
        bxx(32'h80, 32'h4); exp_pred("mid_rst", 1'b0, 32'h0); step();
        bxx(32'h100, 32'h4); exp_pred("rst_bht", 1'b0, 32'h0); step();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            int ty;
            idle();
            ty = $urandom_range(0, 3);
            bus.i_lookup_fire   = ($urandom_range(0, 3) != 0);
            bus.i_pc            = {22'd0, 8'($urandom), 2'b00};
            bus.i_imm           = $urandom;
            bus.i_inst_jal      = (ty == 1);
            bus.i_inst_jalr     = (ty == 2);
            bus.i_inst_bxx      = (ty == 3);
            bus.i_inst_rs1ren   = 1'($urandom);
            bus.i_inst_rd_link  = 1'($urandom);
            bus.i_inst_rs1_link = 1'($urandom);
            bus.i_upd_vld       = 1'($urandom);
            bus.i_upd_pc        = {22'd0, 8'($urandom), 2'b00};
            bus.i_upd_taken     = 1'($urandom);
            bus.i_flush         = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bpu_dyn_bp.md
# bpu_dyn_bp

Parametrised dynamic branch predictor for the fetch/pre-decode stage; the next generation after the static backward-taken predictor. It uses a table of 2-bit saturating counters (BHT) indexed by PC for conditional branches. It keeps jal and rs1-free jalr always-taken, and optionally predicts returns from a return-address stack (RAS). Counters train from BJU resolution; the RAS is flushed on BJU mispredict.

## Interface
Parameters:
- XLEN, 32: data/address width.
- BHT_DEPTH, 64: number of counters; power of two, ≥2.
- RAS_DEPTH, 4: RAS entries; power of two, ≥2 (used only with BPU_RAS_EN).

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rstn  in  1  asynchronous, active-low reset.
- i_lookup_fire  in  1  pre-decoded instruction accepted this cycle; gates all RAS state changes.
- i_pc  in  XLEN  PC of the predicted instruction.
- i_inst_jal, i_inst_jalr, i_inst_bxx  in  1 each  pre-decode type flags; at most one set.
- i_inst_rs1ren  in  1  jalr needs rs1 (rs1≠x0).
- i_inst_rd_link  in  1  rd ∈ {x1,x5}.
- i_inst_rs1_link  in  1  rs1 ∈ {x1,x5}.
- i_imm  in  XLEN  sign-extended immediate.
- o_prdt_taken  out  1  predict taken.
- o_prdt_pc  out  XLEN  predicted target.
- i_upd_vld  in  1  BJU resolved a bxx this cycle.
- i_upd_pc  in  XLEN  PC of the resolved bxx.
- i_upd_taken  in  1  actual outcome.
- i_flush  in  1  BJU mispredict flush.

## Operation
- Index: idx(pc) = pc[log2(BHT_DEPTH)+1:2].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- bxx: taken = bht[idx(i_pc)][1]; target = i_pc + i_imm.
- jal: taken = 1; target = i_pc + i_imm.
- jalr with ~rs1ren: taken = 1; target = i_imm.
- Return (jalr, rs1ren, rs1_link, ~rd_link): with RAS enabled and non-empty, taken = 1, target = RAS top; otherwise taken = 0.
- Any other jalr with rs1ren: taken = 0; BJU resolves it.
- When taken = 0, o_prdt_pc = i_pc + i_imm (don't-care, but deterministic).
- Counter update on i_upd_vld: saturating +1 if taken, −1 otherwise; 11+1 = 11, 00−1 = 00.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update value. No bypass.
- RAS push on fire & (jal|jalr) & rd_link: value = i_pc + 4. When full, overwrite the oldest entry (circular); count saturates at RAS_DEPTH.
- RAS pop on fire & return & non-empty. Pop when empty: no action.
- Push and pop together (jalr rd_link & rs1_link & rs1≠rd): replace the top entry; count unchanged.
- i_flush: RAS count := 0 next edge; flush wins over a same-cycle push/pop. The BHT is not flushed.
- All arithmetic is modulo 2^XLEN.

## Timing
- Prediction is combinational from current state and inputs (0-cycle latency).
- State updates occur at the rising edge of i_clk.
- Update is visible to lookups 1 cycle after i_upd_vld.
- A push is visible to a return in the next cycle.
- Reset (asynchronous on i_rstn low):
  - All counters = 01.
  - RAS count = 0, pointer = 0, entries = 0.
  - Outputs are then purely input-derived: all inputs 0 gives o_prdt_taken = 0, o_prdt_pc = 0.
- Reset mid-update: the in-flight update is discarded.

## Configuration
- BPU_RAS_EN defined: RAS instantiated; returns predicted as above.
- BPU_RAS_EN undefined: no RAS storage; every jalr with rs1ren predicts not-taken.
  - i_inst_rd_link, i_inst_rs1_link and i_flush remain as ports and are ignored.

## Structure
- Counter encodings and the BPU_RAS_EN default belong in config.v.
- The BHT counter array and update logic stay in bpu_dyn_bp.
- Sub-module bpu_ras (push/pop/flush, circular pointer, count) is instantiated under BPU_RAS_EN.

## Test plan
- After reset, bxx at pc=0x100, imm=−8 → taken = 0 (counter 01); target 0xF8.
- Two i_upd_vld taken at pc=0x100 → lookup taken = 1; three not-taken updates → taken = 0; extra updates saturate at 00.
- Same-cycle lookup + update at pc=0x40 with counter 01 → lookup shows not-taken; next cycle shows taken.
- jal at 0x200 with rd_link fired, then return at 0x300 → taken = 1, target 0x204; a second return with RAS empty → taken = 0.
- Five link pushes with RAS_DEPTH=4 (pcs 0x10..0x50, step 0x10) → pops yield 0x54, 0x44, 0x34, 0x24, then empty.
- Push then i_flush in the next cycle → a following return predicts not-taken; with BPU_RAS_EN undefined, every return predicts not-taken.
